// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns a load/store into one valid/ack bus transaction, stalling upstream until it ends.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of truncating the address.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic [1:0]  inMemSize,
  input  logic        inMemSigned,
  input  logic [31:0] inAluLatch,
  input  logic [31:0] inStoreData,
  input  logic [4:0]  inMuxRtRd,
  input  logic        inRegWrite,
  input  logic [1:0]  inMemtoReg,
  output logic        outBusReq,
  output logic        outBusWe,
  output logic [31:0] outBusAddr,
  output logic [31:0] outBusWdata,
  output logic [3:0]  outBusBe,
  input  logic        inBusAck,
  input  logic [31:0] inBusRdata,
  output logic        outStall,
  output logic [31:0] outLoadWordDividerMEM,
  output logic [31:0] outAluLatch,
  output logic [4:0]  outMuxRtRd,
  output logic        outRegWrite,
  output logic [1:0]  outMemtoReg,
  output logic        outBusErr,
  output logic        outMisalign,
  output logic [1:0]  outDbgState
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q;
  logic        we_q, rd_q, sgn_q, err_q, mis_q;
  logic [31:0] addr_q, wdata_q, load_q;
  logic [3:0]  be_q;
  logic [1:0]  size_q, lo_q;
  logic [7:0]  cnt_q;

  logic        op;
  logic        mis_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] fmt_d;
  logic [31:0] rdata_sh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign op = inMemRead | inMemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_d = ((inMemSize == 2'b01) & inAluLatch[0]) | (inMemSize[1] & (|inAluLatch[1:0]));
`else
  assign mis_d = 1'b0;
`endif

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = inStoreData;
    case (inMemSize)
      2'b00: begin
        be_d    = 4'b0001 << inAluLatch[1:0];
        wdata_d = {4{inStoreData[7:0]}};
      end
      2'b01: begin
        be_d    = inAluLatch[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{inStoreData[15:0]}};
      end
      default: ;
    endcase
  end

  // Load formatting uses the size/offset captured at issue, so upstream changes cannot corrupt it.
  assign rdata_sh = inBusRdata >> {lo_q, 3'b000};
  assign byte_sel = rdata_sh[7:0];
  assign half_sel = lo_q[1] ? inBusRdata[31:16] : inBusRdata[15:0];

  always_comb begin
    case (size_q)
      2'b00:   fmt_d = {{24{sgn_q & byte_sel[7]}}, byte_sel};
      2'b01:   fmt_d = {{16{sgn_q & half_sel[15]}}, half_sel};
      default: fmt_d = inBusRdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
      lo_q    <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      load_q  <= 32'h0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op && mis_d) begin
            mis_q   <= 1'b1;
            load_q  <= 32'h0;
            state_q <= DONE;
          end else if (op) begin
            we_q    <= inMemWrite;
            rd_q    <= ~inMemWrite;
            sgn_q   <= inMemSigned;
            size_q  <= inMemSize;
            lo_q    <= inAluLatch[1:0];
            addr_q  <= {inAluLatch[31:2], 2'b00};
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt_q   <= 8'h0;
            state_q <= REQ;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 8'h1;
          if (inBusAck) begin
            load_q  <= rd_q ? fmt_d : 32'h0;
            state_q <= DONE;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            load_q  <= 32'h0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          mis_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign outBusReq             = (state_q == REQ);
  assign outBusWe              = we_q;
  assign outBusAddr            = addr_q;
  assign outBusWdata           = wdata_q;
  assign outBusBe              = be_q;
  assign outLoadWordDividerMEM = load_q;
  assign outBusErr             = err_q;
  assign outMisalign           = mis_q;
  assign outDbgState           = state_q;
  // Gated by rst_n so a reset mid-transaction releases the pipeline in the same instant.
  assign outStall    = rst_n & (((state_q == IDLE) & op) | (state_q == REQ));
  assign outRegWrite = rst_n & inRegWrite & ~outStall & ~err_q & ~mis_q;
  assign outAluLatch = inAluLatch;
  assign outMuxRtRd  = inMuxRtRd;
  assign outMemtoReg = inMemtoReg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: random loads/stores against a transaction-level model, plus directed cases.
module tb_mem_access_stage;

  localparam int TO = 4;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk, rst_n;
  logic        inMemRead, inMemWrite, inMemSigned, inRegWrite, inBusAck;
  logic [1:0]  inMemSize, inMemtoReg;
  logic [31:0] inAluLatch, inStoreData, inBusRdata;
  logic [4:0]  inMuxRtRd;
  logic        outBusReq, outBusWe, outStall, outRegWrite, outBusErr, outMisalign;
  logic [31:0] outBusAddr, outBusWdata, outLoadWordDividerMEM, outAluLatch;
  logic [3:0]  outBusBe;
  logic [4:0]  outMuxRtRd;
  logic [1:0]  outMemtoReg, outDbgState;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .inMemRead(inMemRead), .inMemWrite(inMemWrite), .inMemSize(inMemSize),
    .inMemSigned(inMemSigned), .inAluLatch(inAluLatch), .inStoreData(inStoreData),
    .inMuxRtRd(inMuxRtRd), .inRegWrite(inRegWrite), .inMemtoReg(inMemtoReg),
    .outBusReq(outBusReq), .outBusWe(outBusWe), .outBusAddr(outBusAddr),
    .outBusWdata(outBusWdata), .outBusBe(outBusBe), .inBusAck(inBusAck),
    .inBusRdata(inBusRdata), .outStall(outStall),
    .outLoadWordDividerMEM(outLoadWordDividerMEM), .outAluLatch(outAluLatch),
    .outMuxRtRd(outMuxRtRd), .outRegWrite(outRegWrite), .outMemtoReg(outMemtoReg),
    .outBusErr(outBusErr), .outMisalign(outMisalign), .outDbgState(outDbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        stall, rw, req, err, mis, chk_bus, we, chk_load;
    logic [31:0] addr, wdata, load, alu;
    logic [3:0]  be;
    logic [4:0]  dst;
    logic [1:0]  m2r;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic model_mis(input logic [31:0] a, input logic [1:0] sz);
    if (!TRAP) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz >= 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 4'(32'd1 << (a % 4));
    if (sz == 2'd1) return 4'(32'd3 << (2 * ((a / 2) % 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] model_fmt(input logic [31:0] r, input logic [31:0] a,
                                            input logic [1:0] sz, input logic sg);
    longint v;
    if (sz == 2'd0) begin
      v = longint'((r >> (8 * (a % 4))) & 32'hFF);
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = longint'((r >> (16 * ((a / 2) % 2))) & 32'hFFFF);
      if (sg && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(r);
    end
    return v[31:0];
  endfunction

  // ---------------- bus slave ----------------
  int          ack_k = 1;
  logic [31:0] slave_rdata = 32'h0;

  initial begin
    int req_cnt;
    req_cnt    = 0;
    inBusAck   = 1'b0;
    inBusRdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (outBusReq) begin
        req_cnt++;
        inBusAck   = (req_cnt == ack_k);
        inBusRdata = slave_rdata;
      end else begin
        req_cnt    = 0;
        inBusAck   = ($urandom_range(0, 3) == 0);
        inBusRdata = $urandom;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", 32'(outStall), 32'(e.stall));
        chk("regwrite", 32'(outRegWrite), 32'(e.rw));
        chk("bus_req", 32'(outBusReq), 32'(e.req));
        chk("bus_err", 32'(outBusErr), 32'(e.err));
        chk("misalign", 32'(outMisalign), 32'(e.mis));
        chk("alu_pass", outAluLatch, e.alu);
        chk("rd_pass", 32'(outMuxRtRd), 32'(e.dst));
        chk("m2r_pass", 32'(outMemtoReg), 32'(e.m2r));
        if (e.chk_bus) begin
          chk("bus_we", 32'(outBusWe), 32'(e.we));
          chk("bus_addr", outBusAddr, e.addr);
          chk("bus_be", 32'(outBusBe), 32'(e.be));
          chk("bus_wdata", outBusWdata, e.wdata);
        end
        if (e.chk_load) chk("load_data", outLoadWordDividerMEM, e.load);
      end
    end
  end

  // ---------------- driver ----------------
  int          obs_stalls, obs_req;
  logic [31:0] obs_addr, obs_wdata, obs_load, obs_alu;
  logic [3:0]  obs_be;
  logic        obs_we, obs_err, obs_mis, obs_rw;

  task automatic drive_nop(input logic rw);
    inMemRead = 1'b0; inMemWrite = 1'b0; inMemSize = 2'd0; inMemSigned = 1'b0;
    inAluLatch = 32'h0; inStoreData = 32'h0; inMuxRtRd = 5'd0;
    inRegWrite = rw; inMemtoReg = 2'd0;
  endtask

  // One instruction held in EX/MEM until the stage releases it; k = REQ cycle carrying the ack.
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] dst,
                        input logic rw, input logic [1:0] m2r, input int k,
                        input logic [31:0] rdat);
    int   ncyc;
    logic op, ms, err;
    exp_t e;
    op  = rd | wr;
    ms  = op && model_mis(a, sz);
    err = op && !ms && (k > TO);
    if (!op)     ncyc = 1;
    else if (ms) ncyc = 2;
    else         ncyc = ((k <= TO) ? k : TO) + 2;
    obs_stalls = 0; obs_req = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        inMemRead = rd; inMemWrite = wr; inMemSize = sz; inMemSigned = sg;
        inAluLatch = a; inStoreData = d; inMuxRtRd = dst; inRegWrite = rw; inMemtoReg = m2r;
        ack_k = k; slave_rdata = rdat;
      end
      e = '0;
      e.alu = a; e.dst = dst; e.m2r = m2r;
      if (c == ncyc - 1) begin
        e.err = err;
        e.mis = ms;
        e.rw  = rw & !err & !ms;
        if (rd) begin
          e.chk_load = 1'b1;
          e.load     = (wr || err || ms) ? 32'h0 : model_fmt(rdat, a, sz, sg);
        end
      end else begin
        e.stall   = 1'b1;
        e.req     = (c > 0);
        e.chk_bus = (c > 0);
        e.we      = wr;
        e.addr    = a - (a % 4);
        e.be      = model_be(a, sz);
        e.wdata   = model_wd(d, sz);
      end
      exp_q.push_back(e);
      @(negedge clk);
      if (outStall)  obs_stalls++;
      if (outBusReq) obs_req++;
      if (c == 1) begin
        obs_addr = outBusAddr; obs_wdata = outBusWdata; obs_be = outBusBe; obs_we = outBusWe;
      end
      if (c == ncyc - 1) begin
        obs_load = outLoadWordDividerMEM; obs_err = outBusErr; obs_mis = outMisalign;
        obs_rw = outRegWrite; obs_alu = outAluLatch;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    drive_nop(1'b1);
    inMemRead = 1'b1;
    #3;
    chk("rst_bus_req", 32'(outBusReq), 32'h0);
    chk("rst_bus_we", 32'(outBusWe), 32'h0);
    chk("rst_bus_addr", outBusAddr, 32'h0);
    chk("rst_bus_wdata", outBusWdata, 32'h0);
    chk("rst_bus_be", 32'(outBusBe), 32'h0);
    chk("rst_load", outLoadWordDividerMEM, 32'h0);
    chk("rst_err", 32'(outBusErr), 32'h0);
    chk("rst_mis", 32'(outMisalign), 32'h0);
    chk("rst_stall", 32'(outStall), 32'h0);
    chk("rst_regwrite", 32'(outRegWrite), 32'h0);
    drive_nop(1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // signed byte load, ack on first REQ cycle
    run_op(1, 0, 2'd0, 1, 32'h00000103, 32'h0, 5'd3, 1, 2'd1, 1, 32'h80FF7F01);
    chk("sb_stalls", 32'(obs_stalls), 32'd2);
    chk("sb_load", obs_load, 32'hFFFFFF80);
    chk("sb_regwrite", 32'(obs_rw), 32'd1);

    // unsigned half load, upper lane
    run_op(1, 0, 2'd1, 0, 32'h00000002, 32'h0, 5'd4, 1, 2'd1, 2, 32'h80FF7F01);
    chk("lhu_load", obs_load, 32'h000080FF);
    chk("lhu_stalls", 32'(obs_stalls), 32'd3);

    // half store
    run_op(0, 1, 2'd1, 0, 32'h00000012, 32'h1234ABCD, 5'd0, 0, 2'd0, 1, 32'h0);
    chk("sh_be", 32'(obs_be), 32'hC);
    chk("sh_wdata", obs_wdata, 32'hABCDABCD);
    chk("sh_addr", obs_addr, 32'h00000010);
    chk("sh_we", 32'(obs_we), 32'd1);

    // timeout
    run_op(1, 0, 2'd2, 0, 32'h00000040, 32'h0, 5'd7, 1, 2'd1, 100, 32'h12345678);
    chk("to_req_cycles", 32'(obs_req), 32'(TO));
    chk("to_stalls", 32'(obs_stalls), 32'(TO + 1));
    chk("to_err", 32'(obs_err), 32'd1);
    chk("to_regwrite", 32'(obs_rw), 32'd0);
    chk("to_load", obs_load, 32'h0);

    // ALU-only instruction
    run_op(0, 0, 2'd0, 0, 32'hDEADBEEF, 32'h0, 5'd9, 1, 2'd0, 1, 32'h0);
    chk("alu_stalls", 32'(obs_stalls), 32'd0);
    chk("alu_regwrite", 32'(obs_rw), 32'd1);
    chk("alu_latch", obs_alu, 32'hDEADBEEF);

    // misaligned word load at 0x6
    run_op(1, 0, 2'd2, 0, 32'h00000006, 32'h0, 5'd5, 1, 2'd1, 1, 32'hCAFEF00D);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_req_cycles", 32'(obs_req), 32'd0);
    chk("mis_stalls", 32'(obs_stalls), 32'd1);
    chk("mis_flag", 32'(obs_mis), 32'd1);
    chk("mis_regwrite", 32'(obs_rw), 32'd0);
`else
    chk("mis_addr", obs_addr, 32'h00000004);
    chk("mis_load", obs_load, 32'hCAFEF00D);
`endif

    // reset pulled mid-REQ
    @(posedge clk);
    #1;
    inMemRead = 1'b1; inMemWrite = 1'b0; inMemSize = 2'd2; inAluLatch = 32'h80;
    inRegWrite = 1'b1; ack_k = 200;
    @(posedge clk);
    #1;
    chk("mid_req_active", 32'(outBusReq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(outBusReq), 32'd0);
    chk("mid_rst_stall", 32'(outStall), 32'd0);
    chk("mid_rst_regwrite", 32'(outRegWrite), 32'd0);
    drive_nop(1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    run_op(1, 0, 2'd2, 0, 32'h00000020, 32'h0, 5'd6, 1, 2'd1, 2, 32'h11223344);
    chk("post_rst_load", obs_load, 32'h11223344);
    chk("post_rst_stalls", 32'(obs_stalls), 32'd3);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int   kind;
      logic rd, wr;
      kind = $urandom_range(0, 7);
      rd = (kind inside {[0:3]}) || (kind == 6);
      wr = (kind inside {[4:6]});
      run_op(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 255)) | (32'($urandom) & 32'hFFFF0000), $urandom,
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             $urandom_range(1, TO + 2), $urandom);
    end

    @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
